// File: rtl/arms_pkg.sv
// -----------------------------------------------------------------------------
// arms_pkg
// Shared types for the ARMS writeback trace unit: the register index, the
// 64-bit machine word, the XZR index and the record layout held in the FIFO.
// No ports (package).
// -----------------------------------------------------------------------------
package arms_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 64;
    localparam int NREGS  = 32;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [WORD_W-1:0] word_t;

    // R31 reads as zero on ARMS, so writes to it carry no architectural state.
    localparam reg_idx_t XZR_IDX = 5'd31;

    typedef struct packed {
        reg_idx_t reg_idx;
        word_t    data;
        word_t    pc;
    } trace_rec_t;

endpackage

// File: rtl/arms_wb_trace_fifo_if.sv
// -----------------------------------------------------------------------------
// arms_wb_trace_fifo_if
// Bundles the ARMS writeback bus (iaddrbus, dselect, dbus, wb_en) with the
// trace read handshake (rd_valid/rd_ready plus the head record fields).
//   master : core/host side - drives writeback bus and rd_ready
//   slave  : trace unit     - observes writeback bus, drives read side
// -----------------------------------------------------------------------------
interface arms_wb_trace_fifo_if;
    import arms_pkg::*;

    word_t              iaddrbus;
    logic [NREGS-1:0]   dselect;
    word_t              dbus;
    logic               wb_en;

    logic               rd_valid;
    logic               rd_ready;
    reg_idx_t           rd_reg;
    word_t              rd_data;
    word_t              rd_pc;

    modport master (
        output iaddrbus, dselect, dbus, wb_en, rd_ready,
        input  rd_valid, rd_reg, rd_data, rd_pc
    );

    modport slave (
        input  iaddrbus, dselect, dbus, wb_en, rd_ready,
        output rd_valid, rd_reg, rd_data, rd_pc
    );

endinterface

// File: rtl/arms_onehot_enc.sv
// -----------------------------------------------------------------------------
// arms_onehot_enc
// Converts the 32-bit one-hot writeback select into a register index.
//   sel   in  32  one-hot register select
//   idx   out 5   index of the set bit (OR of indices when multi-hot)
//   zero  out 1   no bit set
//   multi out 1   more than one bit set
// -----------------------------------------------------------------------------
module arms_onehot_enc
    import arms_pkg::*;
(
    input  logic [NREGS-1:0] sel,
    output reg_idx_t         idx,
    output logic             zero,
    output logic             multi
);

    logic seen;

    always_comb begin
        idx   = '0;
        multi = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = idx | reg_idx_t'(i);
            end
        end
        zero = ~seen;
    end

endmodule

// File: rtl/arms_wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// arms_wb_trace_fifo
// Passive capture of ARMS register writebacks into a first-word-fall-through
// FIFO. Each record holds register index, write data and the fetch address of
// the producing instruction (iaddrbus delayed by PIPE_DEPTH cycles).
//   clk        in   1    clock, rising edge
//   reset      in   1    synchronous, active-low reset
//   bus        slave     writeback bus in, read handshake out
//   capture_en in   1    capture enable
//   count      out  $clog2(DEPTH)+1  occupancy
//   overflow   out  1    sticky: record lost because FIFO full
//   sel_err    out  1    sticky: qualified writeback with multi-hot dselect
// -----------------------------------------------------------------------------
module arms_wb_trace_fifo
    import arms_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PIPE_DEPTH = 4,
    parameter bit DROP_XZR   = 1'b1
)(
    input  logic                   clk,
    input  logic                   reset,
    arms_wb_trace_fifo_if.slave    bus,
    input  logic                   capture_en,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   sel_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    word_t            pc_dly [PIPE_DEPTH];
    trace_rec_t       mem    [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    reg_idx_t   enc_idx;
    logic       enc_zero;
    logic       enc_multi;
    logic       cap;
    logic       xzr_hit;
    logic       rec_vld;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;
    trace_rec_t new_rec;
    trace_rec_t head;

    // PC tag delay line: the last stage holds iaddrbus from PIPE_DEPTH cycles
    // back, which is the fetch address of the instruction writing back now.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pc_dly[i] <= '0;
            end
        end else begin
            pc_dly[0] <= bus.iaddrbus;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pc_dly[i] <= pc_dly[i-1];
            end
        end
    end

    arms_onehot_enc u_enc (
        .sel   (bus.dselect),
        .idx   (enc_idx),
        .zero  (enc_zero),
        .multi (enc_multi)
    );

    // wb_en/capture_en are ANDed first so X on dselect while idle is masked.
    assign cap     = capture_en & bus.wb_en & ~enc_zero;
    assign xzr_hit = DROP_XZR && (enc_idx == XZR_IDX);
    assign rec_vld = cap & ~enc_multi & ~xzr_hit;

    assign bus.rd_valid = (count != '0);
    assign full         = (count == FULL_CNT);
    assign pop          = bus.rd_valid & bus.rd_ready;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    assign push         = rec_vld & (~full | pop);
    assign drop         = rec_vld & full & ~pop;

    assign new_rec.reg_idx = enc_idx;
    assign new_rec.data    = bus.dbus;
    assign new_rec.pc      = pc_dly[PIPE_DEPTH-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (cap & enc_multi) begin
                sel_err <= 1'b1;
            end
        end
    end

    // Record storage carries no reset; the read port is masked when empty.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    assign head        = mem[rd_ptr];
    assign bus.rd_reg  = bus.rd_valid ? head.reg_idx : '0;
    assign bus.rd_data = bus.rd_valid ? head.data    : '0;
    assign bus.rd_pc   = bus.rd_valid ? head.pc      : '0;

endmodule

// File: tb/tb_arms_wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_arms_wb_trace_fifo
// Directed bench for arms_wb_trace_fifo with a record scoreboard queue.
// iaddrbus is 4*cycle-since-reset, so the expected PC tag of a writeback in
// cycle t is 4*(t-4), or 0 while the delay line is still filling.
// -----------------------------------------------------------------------------
module tb_arms_wb_trace_fifo;
    import arms_pkg::*;

    localparam int DEPTH = 16;
    localparam int PIPE  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       capture_en = 1'b1;
    logic [4:0] count;
    logic       overflow;
    logic       sel_err;

    arms_wb_trace_fifo_if bus ();

    arms_wb_trace_fifo #(
        .DEPTH      (DEPTH),
        .PIPE_DEPTH (PIPE),
        .DROP_XZR   (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .capture_en (capture_en),
        .count      (count),
        .overflow   (overflow),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    trace_rec_t exp_q [$];
    logic       exp_ovf = 1'b0;
    logic       exp_sel = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic word_t pc_of(input int t);
        return (t >= PIPE) ? word_t'(4 * (t - PIPE)) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.iaddrbus = word_t'(4 * cyc);
    endtask

    task automatic do_reset();
        bus.wb_en    = 1'b0;
        bus.dselect  = '0;
        bus.dbus     = '0;
        bus.rd_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        bus.iaddrbus = '0;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_sel = 1'b0;
        chk("rst_valid", {63'd0, bus.rd_valid}, 64'd0);
        chk("rst_reg",   {59'd0, bus.rd_reg},   64'd0);
        chk("rst_data",  bus.rd_data,           64'd0);
        chk("rst_pc",    bus.rd_pc,             64'd0);
        chk("rst_count", {59'd0, count},        64'd0);
        chk("rst_ovf",   {63'd0, overflow},     64'd0);
        chk("rst_sel",   {63'd0, sel_err},      64'd0);
    endtask

    // One clock cycle: drive inputs, check head against the scoreboard,
    // update the model for this edge, then check occupancy and flags.
    task automatic step(input logic we, input logic [31:0] sel, input word_t data, input logic rdy);
        trace_rec_t rec;
        int         ones;
        logic       pop_m;
        logic       vld_m;
        bus.wb_en    = we;
        bus.dselect  = sel;
        bus.dbus     = data;
        bus.rd_ready = rdy;
        chk("rd_valid", {63'd0, bus.rd_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("head_reg",  {59'd0, bus.rd_reg}, {59'd0, exp_q[0].reg_idx});
            chk("head_data", bus.rd_data,         exp_q[0].data);
            chk("head_pc",   bus.rd_pc,           exp_q[0].pc);
        end
        ones  = $countones(sel);
        vld_m = capture_en && we && (ones == 1) && !sel[31];
        if (capture_en && we && ones > 1) exp_sel = 1'b1;
        pop_m = rdy && (exp_q.size() != 0);
        if (pop_m) void'(exp_q.pop_front());
        if (vld_m) begin
            if (exp_q.size() < DEPTH) begin
                rec.reg_idx = reg_idx_t'($clog2(sel));
                rec.data    = data;
                rec.pc      = pc_of(cyc);
                exp_q.push_back(rec);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        tick();
        bus.wb_en   = 1'b0;
        bus.dselect = '0;
        chk("count",    {59'd0, count},    64'(exp_q.size()));
        chk("overflow", {63'd0, overflow}, {63'd0, exp_ovf});
        chk("sel_err",  {63'd0, sel_err},  {63'd0, exp_sel});
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, '0, rdy);
    endtask

    initial begin
        bus.iaddrbus = '0;
        do_reset();

        // Basic capture: writeback in cycle 4 tags iaddrbus of cycle 0.
        idle(4, 1'b0);
        step(1'b1, 32'(1) << 20, 64'hAAA, 1'b0);
        step(1'b0, 32'd0, '0, 1'b1);
        // Non-zero PC tag once the delay line is full.
        step(1'b1, 32'(1) << 3, 64'h1234_5678_9ABC_DEF0, 1'b0);
        idle(2, 1'b1);

        // capture_en low and X-free idle bus: nothing queued.
        capture_en = 1'b0;
        step(1'b1, 32'(1) << 5, 64'hDEAD, 1'b0);
        capture_en = 1'b1;

        // XZR drop, then multi-hot select.
        step(1'b1, 32'(1) << 31, 64'hBEEF, 1'b0);
        step(1'b1, 32'h3, 64'hCAFE, 1'b0);
        idle(3, 1'b0);

        // Fill past full, drain in order, refill for pointer wrap, drain.
        for (int i = 1; i <= 17; i++) step(1'b1, 32'(1) << i, word_t'(i), 1'b0);
        idle(16, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 32'(1) << (i % 30), word_t'(32'h100 + i), 1'b0);
        idle(16, 1'b1);

        // Simultaneous push and pop on full.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 32'(1) << (i + 2), word_t'(32'h200 + i), 1'b0);
        step(1'b1, 32'(1) << 9, 64'h55, 1'b1);
        idle(16, 1'b1);

        // Backpressure: head R25/0xAAC held, then exactly one pop.
        step(1'b1, 32'(1) << 25, 64'hAAC, 1'b0);
        step(1'b1, 32'(1) << 26, 64'hAAD, 1'b0);
        idle(5, 1'b0);
        step(1'b0, 32'd0, '0, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);

        // Reset mid-operation with queued records and a sticky flag set.
        for (int i = 0; i < 5; i++) step(1'b1, 32'(1) << (i + 10), word_t'(32'h300 + i), 1'b0);
        step(1'b1, 32'h30, 64'h0, 1'b0);
        do_reset();
        idle(2, 1'b0);
        step(1'b1, 32'(1) << 7, 64'h77, 1'b0);
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
